// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: next-PC select encodings, NOP word and fetch FSM states.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PCSRC_W = 2;

  localparam logic [PCSRC_W-1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JALR   = 2'b10;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_HOLD = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: sequential, PC-relative branch/jal, or jalr target with bit 0 cleared.
module pc_next_mux
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0]    pc,
  input  logic [PCSRC_W-1:0] pc_src,
  input  logic [XLEN-1:0]    imm_ext,
  input  logic [XLEN-1:0]    alu_result,
  output logic [XLEN-1:0]    next_pc
);

  // Encoding 2'b11 is unused by the controller and falls back to PC+4.
  always_comb begin
    next_pc = pc + XLEN'(4);
    case (pc_src)
      PCSRC_BRANCH: next_pc = pc + imm_ext;
      PCSRC_JALR:   next_pc = {alu_result[XLEN-1:1], 1'b0};
      default:      next_pc = pc + XLEN'(4);
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem request/response FSM and decoded-field outputs.
// Optional macro FETCH_MISALIGN_CHECK_EN adds a sticky misaligned-target flag that parks the fetch.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PCSRC_W-1:0]  PCSrc,
  input  logic [XLEN-1:0]     ImmExt,
  input  logic [XLEN-1:0]     ALUResult,
  input  logic                commit,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_ready,
  input  logic                imem_rvalid,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic                instr_valid,
  output logic [XLEN-1:0]     Instr,
  output logic [6:0]          OP,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [XLEN-1:0]     PC,
  output logic [XLEN-1:0]     PCPlus4,
  output logic [XLEN-1:0]     retired
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                misalign_err
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] mux_pc;
  logic [XLEN-1:0] target_pc;
  logic            accept_c;
  logic            misalign_c;

  logic            req_d, valid_d;
  logic [XLEN-1:0] instr_d, pc_d, pc_plus4_d, retired_d;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            misalign_d;
`endif

  pc_next_mux u_pc_next_mux (
    .pc         (PC),
    .pc_src     (PCSrc),
    .imm_ext    (ImmExt),
    .alu_result (ALUResult),
    .next_pc    (mux_pc)
  );

  // Without the check, targets are silently word-aligned; with it, they are kept and flagged.
`ifdef FETCH_MISALIGN_CHECK_EN
  assign target_pc  = mux_pc;
  assign misalign_c = |mux_pc[1:0];
`else
  assign target_pc  = {mux_pc[XLEN-1:2], 2'b00};
  assign misalign_c = 1'b0;
`endif

  // A parked HOLD has instr_valid low, so commits there are never accepted.
  assign accept_c = (state_q == ST_HOLD) && instr_valid && commit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ:  if (imem_ready)  state_d = ST_WAIT;
      ST_WAIT: if (imem_rvalid) state_d = ST_HOLD;
      ST_HOLD: if (accept_c && !misalign_c) state_d = ST_REQ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d      = (state_d == ST_REQ);
    valid_d    = instr_valid;
    instr_d    = Instr;
    pc_d       = PC;
    pc_plus4_d = PCPlus4;
    retired_d  = retired;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d = misalign_err;
`endif
    if ((state_q == ST_WAIT) && imem_rvalid) begin
      instr_d = imem_rdata;
      valid_d = 1'b1;
    end
    if (accept_c) begin
      pc_d       = target_pc;
      pc_plus4_d = target_pc + XLEN'(4);
      retired_d  = retired + XLEN'(1);
      valid_d    = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (misalign_c) misalign_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      imem_req     <= 1'b0;
      instr_valid  <= 1'b0;
      Instr        <= NOP;
      PC           <= RESET_PC;
      PCPlus4      <= RESET_PC + XLEN'(4);
      retired      <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      imem_req     <= req_d;
      instr_valid  <= valid_d;
      Instr        <= instr_d;
      PC           <= pc_d;
      PCPlus4      <= pc_plus4_d;
      retired      <= retired_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_err <= misalign_d;
`endif
    end
  end

  assign imem_addr = PC;
  assign OP        = Instr[6:0];
  assign funct3    = Instr[14:12];
  assign funct7    = Instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed corner cases plus randomized fetch/commit traffic.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt, ALUResult;
  logic        commit;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [6:0]  OP;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] PC, PCPlus4, retired;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_pc, exp_ret;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCSrc       (PCSrc),
    .ImmExt      (ImmExt),
    .ALUResult   (ALUResult),
    .commit      (commit),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .Instr       (Instr),
    .OP          (OP),
    .funct3      (funct3),
    .funct7      (funct7),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .retired     (retired)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference next-PC from the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] src,
                                             input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] t;
    if (src == 2'd1)      t = pc + imm;
    else if (src == 2'd2) t = alu & 32'hFFFF_FFFE;
    else                  t = pc + 32'd4;
`ifndef FETCH_MISALIGN_CHECK_EN
    t = t & 32'hFFFF_FFFC;
`endif
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic wait_req();
    for (int n = 0; n < 20 && imem_req !== 1'b1; n++) @(negedge clk);
    chk("req_rise", 32'(imem_req), 32'd1);
  endtask

  // One full REQ/WAIT/HOLD transaction; caller's commit level is left alone until HOLD entry.
  task automatic fetch(input logic [31:0] w, input int rd, input int vd);
    wait_req();
    chk("req_addr", imem_addr, exp_pc);
    for (int i = 0; i < rd; i++) begin
      @(negedge clk);
      chk("req_held", 32'(imem_req), 32'd1);
      chk("pc_stall", PC, exp_pc);
      chk("ret_stall", retired, exp_ret);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    chk("wait_req_low", 32'(imem_req), 32'd0);
    chk("wait_invalid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < vd; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    imem_ready  = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = w;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    chk("hold_valid", 32'(instr_valid), 32'd1);
    chk("instr", Instr, w);
    chk("op", 32'(OP), 32'(w[6:0]));
    chk("funct3", 32'(funct3), 32'(w[14:12]));
    chk("funct7", 32'(funct7), 32'(w[31:25]));
    chk("hold_pc", PC, exp_pc);
    chk("hold_pc4", PCPlus4, exp_pc + 32'd4);
    chk("hold_ret", retired, exp_ret);
    commit = 1'b0;
  endtask

  task automatic do_commit(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu,
                           input bit keep);
    PCSrc = src; ImmExt = imm; ALUResult = alu; commit = 1'b1;
    @(negedge clk);
    if (!keep) commit = 1'b0;
    exp_pc  = model_next(exp_pc, src, imm, alu);
    exp_ret = exp_ret + 32'd1;
    chk("commit_pc", PC, exp_pc);
    chk("commit_pc4", PCPlus4, exp_pc + 32'd4);
    chk("commit_ret", retired, exp_ret);
    chk("commit_invalid", 32'(instr_valid), 32'd0);
    chk("commit_req", 32'(imem_req), 32'(exp_pc[1:0] == 2'b00));
    chk("commit_addr", imem_addr, exp_pc);
  endtask

  initial begin
    rst_n = 1'b0; commit = 1'b0; PCSrc = 2'd0; ImmExt = '0; ALUResult = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    exp_pc = 32'd0; exp_ret = 32'd0;
    #12;
    chk("rst_pc", PC, 32'd0);
    chk("rst_pc4", PCPlus4, 32'd4);
    chk("rst_instr", Instr, 32'h0000_0013);
    chk("rst_op", 32'(OP), 32'h13);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_ret", retired, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_mis", 32'(misalign_err), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_one_cycle", 32'(imem_req), 32'd1);

    fetch(32'h0050_0093, 0, 0);
    do_commit(2'd0, 32'd0, 32'd0, 1'b0);               // 0 -> 4
    fetch($urandom, 1, 0);
    do_commit(2'd2, 32'd0, 32'h0000_0010, 1'b0);       // -> 16
    fetch($urandom, 0, 1);
    do_commit(2'd1, 32'hFFFF_FFF8, 32'd0, 1'b0);       // 16-8 -> 8
    fetch($urandom, 2, 2);
    do_commit(2'd2, 32'd0, 32'h0000_0105, 1'b0);       // -> 0x104

    // Abort a request in WAIT with reset; the stale response must be discarded.
    wait_req();
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_pc", PC, 32'd0);
    chk("abort_ret", retired, 32'd0);
    chk("abort_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 32'd0; exp_ret = 32'd0;
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("stale_instr", Instr, 32'h0000_0013);
    chk("stale_valid", 32'(instr_valid), 32'd0);
    chk("restart_req", 32'(imem_req), 32'd1);
    chk("restart_addr", imem_addr, 32'd0);

    // PC wrap, then commit held high through the next REQ/WAIT (and into HOLD entry).
    fetch($urandom, 0, 0);
    do_commit(2'd2, 32'd0, 32'hFFFF_FFFC, 1'b0);
    fetch($urandom, 0, 0);
    do_commit(2'd0, 32'd0, 32'd0, 1'b1);               // wraps to 0, commit stays high
    fetch($urandom, 5, 1);

    for (int k = 0; k < 30; k++) begin
      do_commit(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC,
                $urandom & 32'hFFFF_FFFD, 1'b0);
      fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Unaligned jalr target: flagged and parked with the check, word-aligned without it.
    do_commit(2'd2, 32'd0, 32'h0000_0102, 1'b0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_flag", 32'(misalign_err), 32'd1);
    commit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("park_req", 32'(imem_req), 32'd0);
      chk("park_ret", retired, exp_ret);
      chk("park_flag", 32'(misalign_err), 32'd1);
    end
    commit = 1'b0;
`else
    fetch($urandom, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
